cb_filter_tracker: RTL and testbench

CB_FILTER_TRACKER -- requirements
Module: cb_filter_tracker

---
 rtl/cb_filter_pkg.sv | 7 +
 rtl/cb_filter.sv | 75 +++++++
 rtl/cb_filter_tracker.sv | 81 ++++++++
 tb/tb_cb_filter_tracker.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cb_filter_pkg.sv
// cb_filter_pkg: seed type shared by the counting Bloom filter and its users
package cb_filter_pkg;
  typedef struct packed {
    logic [31:0] perm_seed;
    logic [31:0] xor_seed;
  } cb_seed_t;
endpackage

// File: rtl/cb_filter.sv
// cb_filter: counting Bloom filter; look_* combinational membership query against pre-update state, incr_*/decr_* bump KHashes buckets, filter_clear_i sync clear, full/error flags
module cb_filter
  import cb_filter_pkg::*;
#(
  parameter int unsigned KHashes = 3,
  parameter int unsigned HashWidth = 6,
  parameter int unsigned HashRounds = 1,
  parameter int unsigned InpWidth = 32,
  parameter int unsigned BucketWidth = 3,
  parameter cb_seed_t [KHashes-1:0] Seeds = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [InpWidth-1:0] look_data_i,
  output logic                look_valid_o,
  input  logic [InpWidth-1:0] incr_data_i,
  input  logic                incr_valid_i,
  input  logic [InpWidth-1:0] decr_data_i,
  input  logic                decr_valid_i,
  input  logic                filter_clear_i,
  output logic                filter_full_o,
  output logic                filter_error_o
);
  localparam int unsigned NumBuckets = 2 ** HashWidth;
  localparam int BucketMax = 2 ** BucketWidth - 1;
  typedef logic [HashWidth-1:0] idx_t;
  logic [BucketWidth-1:0] cnt_q [NumBuckets];
  logic [BucketWidth-1:0] cnt_d [NumBuckets];
  idx_t look_idx [KHashes];
  idx_t incr_idx [KHashes];
  idx_t decr_idx [KHashes];
  function automatic idx_t hash(input logic [InpWidth-1:0] data, input cb_seed_t seed);
    logic [InpWidth-1:0] x;
    int unsigned s;
    idx_t idx;
    for (int i = 0; i < InpWidth; i++) x[i] = data[i] ^ seed.xor_seed[i % 32];
    for (int r = 0; r < HashRounds; r++) begin
      s = (seed.perm_seed + r) % InpWidth;
      x = (x << s) | (x >> (InpWidth - s));
    end
    idx = '0;
    for (int i = 0; i < InpWidth; i++) idx[i % HashWidth] ^= x[i];
    return idx;
  endfunction
  always_comb begin
    look_valid_o = 1'b1;
    for (int k = 0; k < KHashes; k++) begin
      look_idx[k] = hash(look_data_i, Seeds[k]);
      incr_idx[k] = hash(incr_data_i, Seeds[k]);
      decr_idx[k] = hash(decr_data_i, Seeds[k]);
      look_valid_o &= cnt_q[look_idx[k]] != '0;
    end
  end
  // Net per-bucket delta lets an increment and a decrement land in the same cycle; a bucket
  // that would wrap keeps its value and raises error. Full leaves room for one more insert.
  always_comb begin
    filter_error_o = 1'b0;
    filter_full_o = 1'b0;
    for (int b = 0; b < NumBuckets; b++) begin
      int n;
      n = int'(cnt_q[b]);
      for (int k = 0; k < KHashes; k++) begin
        if (incr_valid_i && incr_idx[k] == idx_t'(b)) n++;
        if (decr_valid_i && decr_idx[k] == idx_t'(b)) n--;
      end
      filter_error_o |= n < 0 || n > BucketMax;
      filter_full_o |= int'(cnt_q[b]) > BucketMax - int'(KHashes);
      cnt_d[b] = (n < 0 || n > BucketMax) ? cnt_q[b] : n[BucketWidth-1:0];
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni || filter_clear_i) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cb_filter_tracker.sv
// cb_filter_tracker: in-order outstanding tracker; req_* upstream, mst_* downstream pass-through, retire_i pops oldest, busy_o/count_o occupancy, stall_hazard_o filter hit, error_o sticky
module cb_filter_tracker
  import cb_filter_pkg::*;
#(
  parameter int unsigned InpWidth = 32,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned KHashes = 3,
  parameter int unsigned HashWidth = 6,
  parameter int unsigned HashRounds = 1,
  parameter int unsigned BucketWidth = 3,
  parameter cb_seed_t [KHashes-1:0] Seeds = {
    cb_seed_t'{32'd19, 32'h85eb_ca6b},
    cb_seed_t'{32'd11, 32'hc2b2_ae35},
    cb_seed_t'{32'd5,  32'h9e37_79b9}
  }
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [InpWidth-1:0]                req_data_i,
  output logic                               mst_valid_o,
  input  logic                               mst_ready_i,
  output logic [InpWidth-1:0]                mst_data_o,
  input  logic                               retire_i,
  output logic                               busy_o,
  output logic [$clog2(MaxOutstanding):0]    count_o,
  output logic                               stall_hazard_o,
  output logic                               error_o
);
  localparam int PtrW = $clog2(MaxOutstanding);
  localparam int CntW = PtrW + 1;
  logic [InpWidth-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic hit, flt_full, flt_err, blocked, accept, pop;
  // rst_i folded into blocked so nothing handshakes while the tracker is being cleared
  assign blocked = hit | (count_o == CntW'(MaxOutstanding)) | flt_full | rst_i;
  assign mst_data_o = req_data_i;
  assign mst_valid_o = req_valid_i & ~blocked;
  assign req_ready_o = mst_ready_i & ~blocked;
  assign stall_hazard_o = req_valid_i & hit;
  assign accept = mst_valid_o & mst_ready_i;
  assign busy_o = count_o != '0;
  assign pop = retire_i & busy_o;
  cb_filter #(
    .KHashes(KHashes),
    .HashWidth(HashWidth),
    .HashRounds(HashRounds),
    .InpWidth(InpWidth),
    .BucketWidth(BucketWidth),
    .Seeds(Seeds)
  ) u_filter (
    .clk_i(clk_i),
    .rst_ni(1'b1),
    .look_data_i(req_data_i),
    .look_valid_o(hit),
    .incr_data_i(req_data_i),
    .incr_valid_i(accept),
    .decr_data_i(fifo_q[rd_ptr_q]),
    .decr_valid_i(pop),
    .filter_clear_i(rst_i),
    .filter_full_o(flt_full),
    .filter_error_o(flt_err)
  );
  always_ff @(posedge clk_i) begin
    if (accept) fifo_q[wr_ptr_q] <= req_data_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_o <= '0;
      error_o <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PtrW'(accept);
      rd_ptr_q <= rd_ptr_q + PtrW'(pop);
      count_o <= count_o + CntW'(accept) - CntW'(pop);
      error_o <= error_o | (retire_i & ~pop) | flt_err;
    end
  end
endmodule

// File: tb/tb_cb_filter_tracker.sv
// tb_cb_filter_tracker: directed and scoreboarded random checks of cb_filter_tracker
module tb_cb_filter_tracker;
  import cb_filter_pkg::*;
  localparam cb_seed_t [2:0] TbSeeds = {
    cb_seed_t'{32'd0, 32'h20},
    cb_seed_t'{32'd0, 32'h10},
    cb_seed_t'{32'd0, 32'h00}
  };
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [31:0] req_data_i = '0;
  logic mst_valid_o;
  logic mst_ready_i = 1'b0;
  logic [31:0] mst_data_o;
  logic retire_i = 1'b0;
  logic busy_o;
  logic [3:0] count_o;
  logic stall_hazard_o;
  logic error_o;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  cb_filter_tracker #(.Seeds(TbSeeds)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_data_i(req_data_i),
    .mst_valid_o(mst_valid_o),
    .mst_ready_i(mst_ready_i),
    .mst_data_o(mst_data_o),
    .retire_i(retire_i),
    .busy_o(busy_o),
    .count_o(count_o),
    .stall_hazard_o(stall_hazard_o),
    .error_o(error_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic rdy, input logic ret);
    @(negedge clk);
    rst_i = r;
    req_valid_i = v;
    req_data_i = d;
    mst_ready_i = rdy;
    retire_i = ret;
    #1;
  endtask
  initial begin
    logic [31:0] q [$];
    logic v, rdy, ret, hit, blk;
    logic [31:0] d;
    drive(1, 1, 32'h100, 1, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_valid", mst_valid_o, 0);
    drive(1, 1, 32'h100, 1, 0);
    drive(0, 1, 32'h100, 1, 0);
    chk("rst_count", count_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_error", error_o, 0);
    chk("acc_ready", req_ready_o, 1);
    chk("acc_valid", mst_valid_o, 1);
    chk("acc_data", mst_data_o, 32'h100);
    chk("acc_stall", stall_hazard_o, 0);
    drive(0, 1, 32'h100, 1, 1);
    chk("acc_count", count_o, 1);
    chk("acc_busy", busy_o, 1);
    chk("dup_ready", req_ready_o, 0);
    chk("dup_valid", mst_valid_o, 0);
    chk("dup_stall", stall_hazard_o, 1);
    drive(0, 1, 32'h100, 1, 0);
    chk("ret_count", count_o, 0);
    chk("post_ret_ready", req_ready_o, 1);
    drive(0, 1, 32'h200, 1, 1);
    chk("both_count_pre", count_o, 1);
    chk("both_ready", req_ready_o, 1);
    drive(0, 1, 32'h100, 0, 0);
    chk("both_count", count_o, 1);
    chk("both_look_stall", stall_hazard_o, 0);
    chk("both_look_valid", mst_valid_o, 1);
    chk("both_look_ready", req_ready_o, 0);
    drive(0, 0, 32'h0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 32'(i), 1, 0);
      if (i == 0) chk("fill_start", count_o, 0);
      chk("fill_ready", req_ready_o, 1);
    end
    drive(0, 1, 32'h8, 1, 0);
    chk("full_count", count_o, 8);
    chk("full_ready", req_ready_o, 0);
    chk("full_stall", stall_hazard_o, 0);
    drive(0, 1, 32'h8, 1, 1);
    chk("full_ret_ready", req_ready_o, 0);
    drive(0, 1, 32'h8, 1, 0);
    chk("full_after_ret", count_o, 7);
    chk("wrap_ready", req_ready_o, 1);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 32'h0, 0, 1);
      if (i == 1) chk("wrap_count", count_o, 8);
      drive(0, 1, 32'(i), 0, 0);
      chk("drain_count", count_o, 32'(8 - i));
      chk("drain_miss", stall_hazard_o, 0);
    end
    drive(0, 1, 32'h3, 1, 0);
    drive(1, 0, 32'h0, 0, 0);
    chk("mid_count", count_o, 1);
    drive(0, 0, 32'h0, 0, 1);
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_error", error_o, 0);
    drive(0, 0, 32'h0, 0, 0);
    chk("empty_ret_error", error_o, 1);
    chk("empty_ret_count", count_o, 0);
    drive(0, 1, 32'h3, 1, 0);
    chk("discard_ready", req_ready_o, 1);
    drive(0, 0, 32'h0, 0, 0);
    chk("sticky_error", error_o, 1);
    chk("sticky_count", count_o, 1);
    drive(1, 0, 32'h0, 0, 0);
    drive(0, 0, 32'h0, 0, 0);
    chk("clr_error", error_o, 0);
    chk("clr_count", count_o, 0);
    for (int n = 0; n < 4000; n++) begin
      v = $urandom_range(0, 3) != 0;
      d = $urandom_range(0, 15);
      rdy = $urandom_range(0, 3) != 0;
      ret = q.size() > 0 && $urandom_range(0, 2) == 0;
      drive(0, v, d, rdy, ret);
      hit = 1'b0;
      foreach (q[j]) if (q[j] == d) hit = 1'b1;
      blk = hit || q.size() == 8;
      chk("rnd_count", count_o, q.size());
      chk("rnd_ready", req_ready_o, rdy & ~blk);
      chk("rnd_valid", mst_valid_o, v & ~blk);
      chk("rnd_stall", stall_hazard_o, v & hit);
      if (v && rdy && !blk) q.push_back(d);
      if (ret) void'(q.pop_front());
    end
    for (int n = 0; n < 20 && q.size() > 0; n++) begin
      drive(0, 0, 32'h0, 0, 1);
      void'(q.pop_front());
    end
    chk("drain_done", q.size(), 0);
    drive(0, 0, 32'h0, 0, 0);
    chk("final_count", count_o, 0);
    chk("final_error", error_o, 0);
    for (int a = 0; a < 16; a++) begin
      drive(0, 1, 32'(a), 0, 0);
      chk("final_empty", stall_hazard_o, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
